// File: rtl/display_counter.sv
// Multi-digit hex/BCD up/down counter with load, wrap pulse and seven-segment decode.
// Q/Carry registered (1 cycle); HEX combinational from Q; no backpressure.
module display_counter #(
   parameter int DIGITS = 4
) (
   input  logic                  clock_i,
   input  logic                  resetn_i,
   input  logic                  en_i,
   input  logic                  up_i,
   input  logic                  dec_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   d_i,
   input  logic                  blank_i,
   output logic [4*DIGITS-1:0]   q_o,
   output logic                  carry_o,
   output logic [7*DIGITS-1:0]   hex_o
);

   logic [4*DIGITS-1:0] q_d, q_q;
   logic                carry_d, carry_q;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      logic       ripple;
      logic       co;
      logic [3:0] dig;
      logic [3:0] nxt;
      q_d     = q_q;
      carry_d = 1'b0;
      ripple  = 1'b1;
      co      = 1'b0;
      dig     = 4'd0;
      nxt     = 4'd0;
      if (load_i) begin
         q_d = d_i;
      end else if (en_i) begin
         // ripple stays high only while every lower digit wraps this cycle
         for (int k = 0; k < DIGITS; k++) begin
            dig = q_q[4*k +: 4];
            co  = 1'b0;
            if (up_i) begin
               if ((dec_i && dig >= 4'd9) || (!dec_i && dig == 4'hF)) begin
                  nxt = 4'd0;
                  co  = 1'b1;
               end else begin
                  nxt = dig + 4'd1;
               end
            end else begin
               if (dig == 4'd0) begin
                  nxt = dec_i ? 4'd9 : 4'hF;
                  co  = 1'b1;
               end else if (dec_i && dig > 4'd9) begin
                  nxt = 4'd9;
               end else begin
                  nxt = dig - 4'd1;
               end
            end
            if (ripple) q_d[4*k +: 4] = nxt;
            ripple = ripple & co;
         end
         carry_d = ripple;
      end
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         q_q     <= '0;
         carry_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         carry_q <= carry_d;
      end
   end

   always_comb begin
      logic       zero_above;
      logic [3:0] dig;
      zero_above = 1'b1;
      dig        = 4'd0;
      hex_o      = '0;
      // scan from the top so a digit knows whether everything above it is zero
      for (int k = DIGITS - 1; k >= 0; k--) begin
         dig = q_q[4*k +: 4];
         if (blank_i && (k != 0) && zero_above && (dig == 4'd0))
            hex_o[7*k +: 7] = 7'h7F;
         else
            hex_o[7*k +: 7] = glyph(dig);
         zero_above = zero_above & (dig == 4'd0);
      end
   end

   assign q_o     = q_q;
   assign carry_o = carry_q;

endmodule

// File: tb/tb_display_counter.sv
// Randomized and directed bench for display_counter, checked against an arithmetic model.
module tb_display_counter;

   localparam logic [6:0] GLYPH [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en, up, dec, load, blank;
   logic [7:0]  d, q;
   logic        carry;
   logic [13:0] hex;

   logic        rst4_n, en4, load4;
   logic [15:0] d4, q4;
   logic        carry4;
   logic [27:0] hex4;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   display_counter #(.DIGITS(2)) dut (
      .clock_i(clk), .resetn_i(rst_n), .en_i(en), .up_i(up), .dec_i(dec), .load_i(load),
      .d_i(d), .blank_i(blank), .q_o(q), .carry_o(carry), .hex_o(hex));

   display_counter #(.DIGITS(4)) dut4 (
      .clock_i(clk), .resetn_i(rst4_n), .en_i(en4), .up_i(up), .dec_i(dec), .load_i(load4),
      .d_i(d4), .blank_i(blank), .q_o(q4), .carry_o(carry4), .hex_o(hex4));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Hex: modular arithmetic on the whole value. BCD with valid digits: decimal arithmetic.
   // BCD with invalid digits: per-digit rules applied least significant first.
   function automatic logic [8:0] model_step(input logic [7:0] v, input logic u, input logic dm);
      logic [7:0] nv;
      logic       c;
      int         val, dd, nd;
      bit         act, co;
      nv = v;
      c  = 1'b0;
      if (!dm) begin
         if (u) begin c = (v == 8'hFF); nv = v + 8'd1; end
         else   begin c = (v == 8'h00); nv = v - 8'd1; end
      end else if (int'(v[7:4]) <= 9 && int'(v[3:0]) <= 9) begin
         val = int'(v[7:4]) * 10 + int'(v[3:0]);
         if (u) begin c = (val == 99); val = (val + 1) % 100; end
         else   begin c = (val == 0);  val = (val + 99) % 100; end
         nv = {4'(val / 10), 4'(val % 10)};
      end else begin
         act = 1'b1;
         for (int k = 0; k < 2; k++) begin
            dd = int'(nv[4*k +: 4]);
            co = 1'b0;
            if (u) begin
               if (dd >= 9) begin nd = 0; co = 1'b1; end else nd = dd + 1;
            end else begin
               if (dd == 0) begin nd = 9; co = 1'b1; end
               else if (dd > 9) nd = 9;
               else nd = dd - 1;
            end
            if (act) nv[4*k +: 4] = 4'(nd);
            act = act && co;
         end
         c = act;
      end
      return {c, nv};
   endfunction

   function automatic logic [13:0] model_hex(input logic [7:0] v, input logic b);
      logic [13:0] h;
      int          msd;
      msd = 0;
      for (int k = 0; k < 2; k++) if (v[4*k +: 4] != 4'd0) msd = k;
      for (int k = 0; k < 2; k++) h[7*k +: 7] = (b && k > msd) ? 7'h7F : GLYPH[v[4*k +: 4]];
      return h;
   endfunction

   logic [7:0] m_q;
   logic       m_c;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q = 8'h00;
         m_c = 1'b0;
      end else if (load) begin
         m_q = d;
         m_c = 1'b0;
      end else if (en) begin
         {m_c, m_q} = model_step(m_q, up, dec);
      end else begin
         m_c = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_q", {24'd0, q}, {24'd0, m_q});
         check("model_carry", {31'd0, carry}, {31'd0, m_c});
         check("model_hex", {18'd0, hex}, {18'd0, model_hex(m_q, blank)});
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] edge_vals [0:5];
      edge_vals = '{8'h99, 8'h00, 8'hFF, 8'h98, 8'h9A, 8'hF9};
      rst_n = 1'b0; rst4_n = 1'b0;
      en = 1'b0; up = 1'b0; dec = 1'b0; load = 1'b1; blank = 1'b0; d = 8'h55;
      en4 = 1'b1; load4 = 1'b1; d4 = 16'h4321;
      repeat (2) @(negedge clk);
      #1;
      check("rst_q", {24'd0, q}, 32'h0);
      check("rst_carry", {31'd0, carry}, 32'h0);
      check("rst_hex_noblank", {18'd0, hex}, {18'd0, 7'h40, 7'h40});
      blank = 1'b1;
      #1;
      check("rst_hex_blank", {18'd0, hex}, {18'd0, 7'h7F, 7'h40});
      check("rst4_hex_blank", {4'd0, hex4}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      load = 1'b0; en4 = 1'b0; load4 = 1'b0;
      chk_en = 1'b1;
      rst_n = 1'b1; rst4_n = 1'b1;

      // BCD up count through the full range and the wrap
      dec = 1'b1; up = 1'b1; en = 1'b1; blank = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         check("bcd_up_q", {24'd0, q}, {24'd0, 4'((i % 100) / 10), 4'(i % 10)});
         check("bcd_up_carry", {31'd0, carry}, (i == 100) ? 32'd1 : 32'd0);
      end
      tick();
      check("bcd_after_wrap_q", {24'd0, q}, 32'h01);
      check("bcd_after_wrap_carry", {31'd0, carry}, 32'h0);

      // hex down from zero
      rst_n = 1'b0; #1; rst_n = 1'b1;
      dec = 1'b0; up = 1'b0; en = 1'b1;
      tick();
      check("hex_down_wrap_q", {24'd0, q}, 32'hFF);
      check("hex_down_wrap_carry", {31'd0, carry}, 32'h1);
      tick();
      check("hex_down_next_q", {24'd0, q}, 32'hFE);
      check("hex_down_next_carry", {31'd0, carry}, 32'h0);

      // load beats enable
      load = 1'b1; en = 1'b1; d = 8'h39;
      tick();
      check("load_q", {24'd0, q}, 32'h39);
      check("load_carry", {31'd0, carry}, 32'h0);
      load = 1'b0; dec = 1'b1; up = 1'b1;
      tick();
      check("load_then_up", {24'd0, q}, 32'h40);

      // invalid BCD digit
      load = 1'b1; en = 1'b0; d = 8'h0C;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      check("bcd_invalid_up", {24'd0, q}, 32'h10);
      load = 1'b1; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b0;
      tick();
      check("bcd_invalid_down", {24'd0, q}, 32'h09);
      check("bcd_invalid_down_carry", {31'd0, carry}, 32'h0);

      // leading-zero blanking
      en = 1'b0; load = 1'b1; d = 8'h05; blank = 1'b1;
      tick();
      load = 1'b0;
      check("blank_05", {18'd0, hex}, {18'd0, 7'h7F, 7'h12});
      load = 1'b1; d = 8'h00;
      tick();
      load = 1'b0;
      check("blank_00", {18'd0, hex}, {18'd0, 7'h7F, 7'h40});
      load = 1'b1; d = 8'h05; blank = 1'b0;
      tick();
      load = 1'b0;
      check("noblank_05", {18'd0, hex}, {18'd0, 7'h40, 7'h12});

      // four-digit async reset in mid-count
      dec = 1'b1; up = 1'b1; load4 = 1'b1; d4 = 16'h1234;
      tick();
      load4 = 1'b0; en4 = 1'b1;
      tick();
      check("d4_count", {16'd0, q4}, 32'h1235);
      rst4_n = 1'b0;
      #1;
      check("d4_async_rst_q", {16'd0, q4}, 32'h0);
      check("d4_async_rst_carry", {31'd0, carry4}, 32'h0);
      check("d4_async_rst_hex", {4'd0, hex4}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h40});
      rst4_n = 1'b1;
      tick();
      check("d4_first_edge", {16'd0, q4}, 32'h0001);
      en4 = 1'b0;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         en    = ($urandom_range(0, 3) != 0);
         up    = 1'($urandom);
         dec   = 1'($urandom);
         blank = 1'($urandom);
         load  = ($urandom_range(0, 15) == 0);
         d     = ($urandom_range(0, 1) == 0) ? edge_vals[$urandom_range(0, 5)] : 8'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0; #1; rst_n = 1'b1;
         end
         tick();
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_counter.md
DISPLAY_COUNTER -- requirements
Module: display_counter

Interface
REQ-001 Parameter DIGITS, default 4, legal 1..8: number of 4-bit digits and seven-segment outputs.
REQ-002 Clock  input  1  sole clock; all state changes on rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 En  input  1  count enable.
REQ-005 Up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 Dec  input  1  mode: 1 = BCD (digits 0-9), 0 = hex (digits 0-F).
REQ-007 Load  input  1  synchronous parallel load.
REQ-008 D  input  4*DIGITS  load value; D[3:0] is the least significant digit.
REQ-009 Blank  input  1  leading-zero blanking enable.
REQ-010 Q  output  4*DIGITS  registered count; Q[3:0] is the least significant digit.
REQ-011 Carry  output  1  registered full-count wrap pulse.
REQ-012 HEX  output  7*DIGITS  active-low segments; HEX[7k+6:7k] drives digit k; bit0=a ... bit6=g.

Function
REQ-013 Priority at each edge SHALL be Load > En > hold.
REQ-014 Load=1 SHALL set Q=D and Carry=0 regardless of En, Up or Dec; D digits above 9 SHALL be stored unchanged in BCD mode.
REQ-015 En=1, Load=0 SHALL change Q by exactly one count, with digit carry/borrow rippling through all digits in the same cycle.
REQ-016 Hex up: digit F->0 with carry into the next digit; hex down: 0->F with borrow.
REQ-017 BCD up: 9->0 with carry; BCD down: 0->9 with borrow.
REQ-018 BCD mode, invalid digit (A-F): up SHALL give 0 with carry; down SHALL give 9 with no borrow.
REQ-019 A digit SHALL change only if it is digit 0 or all lower digits carry/borrow this cycle.
REQ-020 Carry SHALL be 1 for exactly the cycle after an edge where the most significant digit carries or borrows out (up: all digits max->0; down: all 0->max); 0 otherwise.
REQ-021 En=0 with Load=0 SHALL hold Q and clear Carry.
REQ-022 Changes to Dec or Up SHALL affect only subsequent edges and never alter the stored Q.
REQ-023 HEX SHALL be combinational from Q and Blank (zero latency behind Q) using glyphs 0-9, A, b, C, d, E, F.
REQ-024 With Blank=1, each digit above the most significant nonzero digit SHALL display 7'h7F (all off); digit 0 SHALL never be blanked.
REQ-025 With Blank=0, all digits SHALL display their glyph.

Reset
REQ-026 Resetn=0 SHALL immediately, without a clock edge, force Q=0 and Carry=0, overriding Load and En.
REQ-027 During and after reset, HEX digit 0 SHALL be 7'h40; other digits 7'h40, or 7'h7F if Blank=1.
REQ-028 On Resetn release, the first edge with Resetn=1 SHALL count or load normally.

Verification (DIGITS=2 unless noted)
REQ-029 Reset, Dec=1, Up=1, En=1 for 100 edges -> Q steps 00,01..99, then Q=00 with Carry=1 for one cycle only.
REQ-030 Dec=0, Up=0, Q=00, one En edge -> Q=FF, Carry=1; next edge -> Q=FE, Carry=0.
REQ-031 Load=1, En=1, D=8'h39 -> Q=39, Carry=0; next En edge (Dec=1, Up=1) -> Q=40.
REQ-032 Dec=1, load 8'h0C, one up edge -> Q=10; load 8'h0C, one down edge -> Q=09.
REQ-033 Blank=1: Q=05 -> HEX[13:7]=7'h7F, HEX[6:0]=7'h12; Q=00 -> 7'h7F, 7'h40; Blank=0, Q=05 -> 7'h40, 7'h12.
REQ-034 DIGITS=4, counting at Q=1234, Resetn pulsed low between edges -> Q=0000 and Carry=0 before the next edge.
